// File: rtl/fft_out_reorder.sv
// fft_out_reorder: reorders the two bit-reversed MDC FFT output lanes into a natural-order bin stream via ping-pong banks.
// Optional macro FFT_REORDER_DROPCNT_EN adds a saturating dropped-frame counter output drop_cnt.
module fft_out_reorder #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic          in_sop,
  input  logic [DW-1:0] in_re0,
  input  logic [DW-1:0] in_im0,
  input  logic [DW-1:0] in_re1,
  input  logic [DW-1:0] in_im1,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_re,
  output logic [DW-1:0] out_im,
  output logic [4:0]    out_idx,
  output logic          out_last,
  output logic          drop_pulse,
`ifdef FFT_REORDER_DROPCNT_EN
  output logic [7:0]    drop_cnt,
`endif
  output logic          sync_err
);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL, READING} bank_st_t;
  bank_st_t st [2];
  bank_st_t st_nx [2];
  logic [2*DW-1:0] mem [2][32];
  logic [3:0] wbeat, wbeat_nx;
  logic wb, wb_nx, old, old_nx;
  logic [4:0] rd_idx, rd_idx_nx;
  logic filling, has_empty, any_full, rd_act, rb, cb, pick;
  logic claim, restart, cont, drop, last_beat, bypass, hs, fin, we, wsel;
  logic [3:0] beat;
  logic [4:0] a0;
  logic [2*DW-1:0] rd_word;
  assign filling   = (st[0] == FILLING) || (st[1] == FILLING);
  assign has_empty = (st[0] == EMPTY) || (st[1] == EMPTY);
  assign any_full  = (st[0] == FULL) || (st[1] == FULL);
  assign rd_act    = (st[0] == READING) || (st[1] == READING);
  assign rb        = st[1] == READING;
  assign cb        = st[0] != EMPTY;
  assign pick      = (st[0] == FULL && st[1] == FULL) ? old : (st[1] == FULL);
  assign claim     = in_valid && in_sop && !filling && has_empty;
  assign drop      = in_valid && in_sop && !filling && !has_empty;
  assign restart   = in_valid && in_sop && filling;
  assign cont      = in_valid && !in_sop && filling;
  assign last_beat = cont && wbeat == 4'd15;
  // an idle read side takes a just-completed bank straight to READING for 1-cycle latency
  assign bypass    = last_beat && !rd_act && !any_full;
  assign hs        = rd_act && out_ready;
  assign fin       = hs && rd_idx == 5'd31;
  assign we        = claim || restart || cont;
  assign wsel      = claim ? cb : wb;
  assign beat      = in_sop ? 4'd0 : wbeat;
  assign a0        = {beat[0], beat[1], beat[2], beat[3], 1'b0};
  assign rd_word   = mem[rb][rd_idx];
  assign out_valid = rd_act;
  assign out_idx   = rd_act ? rd_idx : 5'd0;
  assign out_last  = rd_act && rd_idx == 5'd31;
  assign out_re    = rd_act ? rd_word[2*DW-1:DW] : '0;
  assign out_im    = rd_act ? rd_word[DW-1:0] : '0;
  always_comb begin
    st_nx = st;
    wb_nx = wb;
    wbeat_nx = wbeat;
    old_nx = old;
    rd_idx_nx = rd_idx + {4'd0, hs};
    if (claim) begin
      st_nx[cb] = FILLING;
      wb_nx = cb;
      wbeat_nx = 4'd1;
    end else if (restart) wbeat_nx = 4'd1;
    else if (cont) begin
      wbeat_nx = wbeat + 4'd1;
      if (last_beat) begin
        st_nx[wb] = bypass ? READING : FULL;
        old_nx = (st[~wb] == FULL) ? ~wb : wb;
      end
    end
    if (fin) st_nx[rb] = EMPTY;
    else if (!rd_act && any_full) st_nx[pick] = READING;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st[0] <= EMPTY;
      st[1] <= EMPTY;
      wb <= 1'b0;
      wbeat <= 4'd0;
      old <= 1'b0;
      rd_idx <= 5'd0;
      drop_pulse <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      st <= st_nx;
      wb <= wb_nx;
      wbeat <= wbeat_nx;
      old <= old_nx;
      rd_idx <= rd_idx_nx;
      drop_pulse <= drop;
      sync_err <= restart;
    end
  end
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wsel][a0] <= {in_re0, in_im0};
      mem[wsel][{a0[4:1], 1'b1}] <= {in_re1, in_im1};
    end
  end
`ifdef FFT_REORDER_DROPCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt <= 8'd0;
    else if (drop && drop_cnt != 8'd255) drop_cnt <= drop_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: scoreboard bench for fft_out_reorder; expected bins are pushed when frames are driven.
module tb_fft_out_reorder;
  localparam int DW = 16;
  logic clk = 0, rst_n = 0;
  logic in_valid = 0, in_sop = 0, out_ready = 0;
  logic [DW-1:0] in_re0 = 0, in_im0 = 0, in_re1 = 0, in_im1 = 0;
  logic out_valid, out_last, drop_pulse, sync_err;
  logic [DW-1:0] out_re, out_im;
  logic [4:0] out_idx;
`ifdef FFT_REORDER_DROPCNT_EN
  logic [7:0] drop_cnt;
`endif
  typedef struct packed {logic [4:0] idx; logic [15:0] re; logic [15:0] im;} smp_t;
  smp_t q [$];
  int checks = 0, failures = 0;
  int drop_hi = 0, sync_hi = 0, gap = 0, last_gap = -1;
  bit after_last = 0, prev_stall = 0;
  smp_t prev_s;
  logic prev_last;

  fft_out_reorder #(.DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
    .in_re0(in_re0), .in_im0(in_im0), .in_re1(in_re1), .in_im1(in_im1),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_idx(out_idx), .out_last(out_last), .drop_pulse(drop_pulse),
`ifdef FFT_REORDER_DROPCNT_EN
    .drop_cnt(drop_cnt),
`endif
    .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // bin carried by lane 0 on beat k: 5-bit reversal of k
  function automatic int rev5(input int k);
    int r = 0;
    for (int b = 0; b < 5; b++) if ((k >> b) & 1) r |= 1 << (4 - b);
    return r;
  endfunction

  task automatic send_frame(input int base, input int nb, input bit push, input bit rel);
    logic [15:0] ev [32];
    for (int k = 0; k < nb; k++) begin
      @(posedge clk); #1;
      if (k == 0 && rel) out_ready = 1;
      in_valid = 1;
      in_sop = (k == 0);
      in_re0 = 16'(base + 2 * k);
      in_re1 = 16'(base + 2 * k + 1);
      in_im0 = in_re0 ^ 16'h5a5a;
      in_im1 = in_re1 ^ 16'h5a5a;
      ev[rev5(k)] = in_re0;
      ev[rev5(k) + 1] = in_re1;
    end
    if (push && nb == 16)
      for (int n = 0; n < 32; n++) q.push_back('{idx: 5'(n), re: ev[n], im: ev[n] ^ 16'h5a5a});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 0;
      in_sop = 0;
    end
  endtask

  task automatic drain(input string tag);
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) break;
    end
    if (i == 400) check(tag, 64'(q.size()), 0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
      after_last = 0;
    end else begin
      if (drop_pulse) drop_hi++;
      if (sync_err) sync_hi++;
      if (prev_stall) begin
        check("stall_hold", {out_valid, out_last, out_idx, out_re, out_im},
              {1'b1, prev_last, prev_s.idx, prev_s.re, prev_s.im});
      end
      if (after_last && !out_valid) gap++;
      if (after_last && out_valid) begin
        last_gap = gap;
        after_last = 0;
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("unexpected_out", {out_idx, out_re, out_im}, 0);
        else begin
          smp_t e;
          e = q.pop_front();
          check("out_sample", {out_idx, out_re, out_im}, {e.idx, e.re, e.im});
          check("out_last", out_last, e.idx == 5'd31);
        end
        if (out_last) begin
          after_last = 1;
          gap = 0;
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_s = '{idx: out_idx, re: out_re, im: out_im};
      prev_last = out_last;
    end
  end

  initial begin
    int d0, s0, i;
    #12;
    check("rst_outs", {out_valid, out_idx, out_last, drop_pulse, sync_err, out_re, out_im}, 0);
    @(posedge clk); #1; rst_n = 1;
    // single frame with natural-order check and 1-cycle latency
    out_ready = 1;
    send_frame(0, 16, 1, 0);
    @(negedge clk);
    check("pre_latency", out_valid, 0);
    @(posedge clk); #1; in_valid = 0; in_sop = 0;
    @(negedge clk);
    check("latency", out_valid, 1);
    check("first_idx", out_idx, 0);
    drain("drain_single");
    // backpressure pattern 1,0,0,1
    fork
      send_frame(1000, 16, 1, 0);
      begin
        for (int j = 0; j < 200; j++) begin
          @(posedge clk); #1;
          out_ready = (j % 4 == 0) || (j % 4 == 3);
        end
        out_ready = 1;
      end
    join_any
    idle(1);
    wait fork;
    drain("drain_bp");
    // three back-to-back frames, third dropped
    out_ready = 0;
    d0 = drop_hi;
    send_frame(2000, 16, 1, 0);
    send_frame(3000, 16, 1, 0);
    send_frame(4000, 16, 0, 1);
    idle(1);
    drain("drain_abc");
    check("drop_pulses", 64'(drop_hi - d0), 1);
    check("frame_gap", 64'(last_gap), 1);
`ifdef FFT_REORDER_DROPCNT_EN
    check("drop_cnt_1", drop_cnt, 1);
`endif
    // mid-frame sop at beat 7
    s0 = sync_hi;
    send_frame(5000, 7, 0, 0);
    send_frame(6000, 16, 1, 0);
    idle(1);
    drain("drain_sync");
    check("sync_pulses", 64'(sync_hi - s0), 1);
    // reset while output idx 10 is presented
    send_frame(7000, 16, 1, 0);
    idle(1);
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (out_valid && out_idx == 5'd10) break;
    end
    if (i == 100) check("rst_wait", 0, 1);
    #2 rst_n = 0;
    #1;
    check("rst_async", {out_valid, out_idx, out_last}, 0);
    q.delete();
    idle(2);
    rst_n = 1;
    @(negedge clk);
    check("rst_empty", out_valid, 0);
    send_frame(8000, 16, 1, 0);
    idle(1);
    drain("drain_post_rst");
    // 300 drops with both banks occupied
    out_ready = 0;
    d0 = drop_hi;
    send_frame(9000, 16, 0, 0);
    send_frame(10000, 16, 0, 0);
    for (int j = 0; j < 300; j++) begin
      @(posedge clk); #1;
      in_valid = 1;
      in_sop = 1;
    end
    idle(2);
    @(negedge clk);
    check("drop_300", 64'(drop_hi - d0), 300);
`ifdef FFT_REORDER_DROPCNT_EN
    check("drop_cnt_sat", drop_cnt, 255);
`endif
    rst_n = 0;
    #1;
    check("final_rst", {out_valid, drop_pulse}, 0);
    check("queue_empty", 64'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
